// File: rtl/mux2_1.sv
// mux2_1 -- WIDTH-wide 2:1 selector, one leaf/node of the mux8_1 tree.
//   a   : data routed to y when sel=0
//   b   : data routed to y when sel=1
//   sel : select
//   y   : selected data (combinational)
module mux2_1 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux8_1.sv
// mux8_1 -- registered 8:1 multiplexer.
//   clk   : rising-edge clock for the output register
//   rst_n : asynchronous active-low reset, clears Y
//   en    : output register load enable (1 = load, 0 = hold)
//   D0..D7: WIDTH-bit data inputs
//   S     : binary select, S=n routes Dn
//   Y     : registered selected data, one clock after the sample edge
// Selection is a three-level tree of mux2_1 cells: S[0] picks within pairs,
// S[1] between pairs, S[2] at the root. Only the final register is clocked,
// so Y has no combinational path from any input.
module mux8_1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [WIDTH-1:0] D3,
  input  logic [WIDTH-1:0] D4,
  input  logic [WIDTH-1:0] D5,
  input  logic [WIDTH-1:0] D6,
  input  logic [WIDTH-1:0] D7,
  input  logic [2:0]       S,
  output logic [WIDTH-1:0] Y
);

  // d_vec[n] = Dn
  logic [7:0][WIDTH-1:0] d_vec;
  logic [3:0][WIDTH-1:0] lvl0;
  logic [1:0][WIDTH-1:0] lvl1;
  logic [WIDTH-1:0]      sel_d;

  assign d_vec = {D7, D6, D5, D4, D3, D2, D1, D0};

  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_lvl0
      mux2_1 #(.WIDTH(WIDTH)) u_mux (
        .a   (d_vec[2*i]),
        .b   (d_vec[2*i+1]),
        .sel (S[0]),
        .y   (lvl0[i])
      );
    end
    for (i = 0; i < 2; i++) begin : g_lvl1
      mux2_1 #(.WIDTH(WIDTH)) u_mux (
        .a   (lvl0[2*i]),
        .b   (lvl0[2*i+1]),
        .sel (S[1]),
        .y   (lvl1[i])
      );
    end
  endgenerate

  mux2_1 #(.WIDTH(WIDTH)) u_root (
    .a   (lvl1[0]),
    .b   (lvl1[1]),
    .sel (S[2]),
    .y   (sel_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  Y <= '0;
    else if (en) Y <= sel_d;
  end

endmodule

// File: tb/tb_mux8_1.sv
module tb_mux8_1;

  logic            clk;
  logic            rst_n;
  logic            en;
  logic [2:0]      s;
  logic [7:0]      d1;        // d1[n] feeds Dn of the WIDTH=1 instance
  logic [7:0][7:0] d8;        // d8[n] feeds Dn of the WIDTH=8 instance
  logic [0:0]      y1;
  logic [7:0]      y8;

  int total = 0;
  int bad   = 0;

  mux8_1 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .D0(d1[0]), .D1(d1[1]), .D2(d1[2]), .D3(d1[3]),
    .D4(d1[4]), .D5(d1[5]), .D6(d1[6]), .D7(d1[7]),
    .S(s), .Y(y1)
  );

  mux8_1 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .D0(d8[0]), .D1(d8[1]), .D2(d8[2]), .D3(d8[3]),
    .D4(d8[4]), .D5(d8[5]), .D6(d8[6]), .D7(d8[7]),
    .S(s), .Y(y8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance to 1 ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (y1 !== 1'b0 || y8 !== 8'h00) begin
      bad++; $display("FAIL reset_initial y1=%b y8=%h want 0/00", y1, y8);
    end
    en = 1'b1; d1 = 8'hFF; d8 = {8{8'hFF}};
    tick(); tick();
    total++;
    if (y1 !== 1'b0 || y8 !== 8'h00) begin
      bad++; $display("FAIL reset_held y1=%b y8=%h want 0/00", y1, y8);
    end
    // release with en low: Y must stay 0
    en = 1'b0; rst_n = 1'b1; s = 3'd3;
    tick();
    total++;
    if (y1 !== 1'b0 || y8 !== 8'h00) begin
      bad++; $display("FAIL reset_release_hold y1=%b y8=%h want 0/00", y1, y8);
    end
    en = 1'b1;
    tick();
    total++;
    if (y1 !== 1'b1 || y8 !== 8'hFF) begin
      bad++; $display("FAIL first_load y1=%b y8=%h want 1/ff", y1, y8);
    end
    // async assert mid-cycle clears Y before any edge
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (y1 !== 1'b0 || y8 !== 8'h00) begin
      bad++; $display("FAIL reset_async y1=%b y8=%h want 0/00", y1, y8);
    end
    tick();
    total++;
    if (y1 !== 1'b0 || y8 !== 8'h00) begin
      bad++; $display("FAIL reset_over_en y1=%b y8=%h want 0/00", y1, y8);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    logic [7:0] pat;
    logic [7:0] exp_seq;
    logic       prev;
    pat = 8'b1010_0110;           // {D0..D7}, D0 is the MSB
    exp_seq = 8'b1010_0110;       // expected Y for S=0..7, S=0 in the MSB
    for (int i = 0; i < 8; i++) begin
      d1[i] = pat[7-i];
      d8[i] = 8'h30 + 8'(i);
    end
    en = 1'b1;
    prev = y1;
    for (int i = 0; i < 8; i++) begin
      s = 3'(i);
      #1;
      total++;
      if (y1 !== prev) begin
        bad++; $display("FAIL sweep_latency s=%0d y1=%b want %b", i, y1, prev);
      end
      tick();
      total++;
      if (y1 !== exp_seq[7-i] || y8 !== 8'h30 + 8'(i)) begin
        bad++; $display("FAIL sweep s=%0d y1=%b y8=%h want %b/%h", i, y1, y8,
                        exp_seq[7-i], 8'h30 + 8'(i));
      end
      prev = exp_seq[7-i];
    end
  endtask

  task automatic test_hold();
    d1 = 8'b0000_0001; s = 3'd0; en = 1'b1;
    tick();
    total++;
    if (y1 !== 1'b1) begin
      bad++; $display("FAIL hold_setup y1=%b want 1", y1);
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s  = 3'(i + 1);
      d1 = 8'h00 ^ 8'(i * 37);
      d8 = {8{8'(i * 11)}};
      tick();
      total++;
      if (y1 !== 1'b1) begin
        bad++; $display("FAIL hold cyc=%0d y1=%b want 1", i, y1);
      end
    end
    en = 1'b1; s = 3'd3; d1 = 8'b1111_0111;   // D3=0
    tick();
    total++;
    if (y1 !== 1'b0) begin
      bad++; $display("FAIL hold_reload y1=%b want 0", y1);
    end
  endtask

  task automatic test_glitch();
    d1 = 8'b0000_0100;            // only D2 high
    en = 1'b1; s = 3'd5;
    tick();                       // Y = D5 = 0
    s = 3'd2; #1 s = 3'd5; #1 s = 3'd2; #1 s = 3'd7;
    total++;
    if (y1 !== 1'b0) begin
      bad++; $display("FAIL glitch_between y1=%b want 0", y1);
    end
    #1 s = 3'd0;
    tick();
    total++;
    if (y1 !== 1'b0) begin
      bad++; $display("FAIL glitch_edge0 y1=%b want 0", y1);
    end
    s = 3'd0; #1 s = 3'd6; #2 s = 3'd2;
    tick();
    total++;
    if (y1 !== 1'b1) begin
      bad++; $display("FAIL glitch_edge2 y1=%b want 1", y1);
    end
  endtask

  task automatic test_reset_midrun();
    d1 = 8'b0010_0100;            // D2=1, D5=1
    en = 1'b1; s = 3'd2;
    tick();
    total++;
    if (y1 !== 1'b1) begin
      bad++; $display("FAIL midrun_setup y1=%b want 1", y1);
    end
    s = 3'd5;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (y1 !== 1'b0 || y8 !== 8'h00) begin
      bad++; $display("FAIL midrun_clear y1=%b y8=%h want 0/00", y1, y8);
    end
    #2 rst_n = 1'b1;
    tick();
    total++;
    if (y1 !== 1'b1) begin
      bad++; $display("FAIL midrun_resume y1=%b want 1", y1);
    end
  endtask

  task automatic test_random();
    logic [0:0] exp1;
    logic [7:0] exp8;
    int errs;
    exp1 = y1 ^ 1'b0;
    exp8 = y8;
    // seed the model from a known state
    en = 1'b1; s = 3'd0; d1 = 8'h00; d8 = '0;
    tick();
    exp1 = 1'b0; exp8 = 8'h00;
    errs = 0;
    for (int c = 0; c < 1000; c++) begin
      d1 = 8'($urandom);
      for (int i = 0; i < 8; i++) d8[i] = 8'($urandom);
      s  = 3'($urandom_range(0, 7));
      en = 1'($urandom);
      if (en) begin
        exp1 = d1[s];
        exp8 = d8[s];
      end
      tick();
      total++;
      if (y1 !== exp1 || y8 !== exp8) begin
        bad++;
        if (errs < 10)
          $display("FAIL random cyc=%0d y1=%b y8=%h want %b/%h", c, y1, y8, exp1, exp8);
        errs++;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; s = 3'd0; d1 = '0; d8 = '0;
    test_reset();
    test_sweep();
    test_hold();
    test_glitch();
    test_reset_midrun();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
